// File: rtl/stochastic_alu_param.sv
// -----------------------------------------------------------------------------
// stochastic_alu_param
//
// Parametrised stochastic arithmetic unit. Two WIDTH-bit probabilities are
// shifted in serially (LSB first). Each one becomes a stochastic bitstream by
// comparing it against its own 31-bit LFSR. The two streams are combined in
// one of four modes, and the ones are counted over a 2^CNT_LOG2-cycle window.
// The saturated count, scaled to WIDTH bits, is published together with an
// overflow flag and a one-cycle valid pulse.
//
// Ports
//   clk           clock
//   rst_n         asynchronous reset, active-high (legacy name)
//   load_start    IDLE only: start serial operand load, latch mode
//   ser_a/ser_b   operand serial bits, LSB first
//   mode          00 bipolar mul (XNOR), 01 scaled add (MUX),
//                 10 unipolar mul (AND), 11 pass A
//   cont          sampled in DONE: 1 re-run with same operands, 0 go idle
//   abort         LOAD/RUN: return to IDLE without publishing
//   result        saturated window count, WIDTH MSBs of the count
//   result_ovf    count reached exactly 2^CNT_LOG2
//   result_valid  one-cycle pulse when result/result_ovf update
//   busy          high in LOAD, RUN and DONE
//
// state | meaning
// IDLE  | waiting for load_start
// LOAD  | shifting in WIDTH operand bits
// RUN   | streaming and counting for 2^CNT_LOG2 cycles
// DONE  | publish result, then re-run or go idle
// -----------------------------------------------------------------------------
module stochastic_alu_param #(
    parameter int          WIDTH    = 9,
    parameter int          CNT_LOG2 = 17,
    parameter logic [30:0] SEED_A   = 31'd134995,
    parameter logic [30:0] SEED_B   = 31'd7654321,
    parameter logic [30:0] SEED_S   = 31'd1000003
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             ser_a,
    input  logic             ser_b,
    input  logic [1:0]       mode,
    input  logic             cont,
    input  logic             abort,
    output logic [WIDTH-1:0] result,
    output logic             result_ovf,
    output logic             result_valid,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [30:0] SEED_A_EFF = (SEED_A == 31'd0) ? 31'd1 : SEED_A;
    localparam logic [30:0] SEED_B_EFF = (SEED_B == 31'd0) ? 31'd1 : SEED_B;
    localparam logic [30:0] SEED_S_EFF = (SEED_S == 31'd0) ? 31'd1 : SEED_S;

    localparam int              BIT_W    = $clog2(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_t                state;
    logic [1:0]            mode_q;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic [BIT_W-1:0]      bit_idx;
    logic [30:0]           lfsr_a;
    logic [30:0]           lfsr_b;
    logic [30:0]           lfsr_s;
    logic [CNT_LOG2:0]     cnt;
    logic [CNT_LOG2-1:0]   win;

    logic                  sa;
    logic                  sb;
    logic                  sel;
    logic                  out_bit;
    logic [CNT_LOG2:0]     cnt_nxt;
    logic [WIDTH-1:0]      result_nxt;

    assign sa  = (lfsr_a[WIDTH-1:0] < op_a);
    assign sb  = (lfsr_b[WIDTH-1:0] < op_b);
    assign sel = lfsr_s[WIDTH-1];

    always_comb begin
        out_bit = 1'b0;
        case (mode_q)
            2'b00:   out_bit = ~(sa ^ sb);
            2'b01:   out_bit = sel ? sb : sa;
            2'b10:   out_bit = sa & sb;
            default: out_bit = sa;
        endcase
    end

    // The counter is one bit wider than the window so a full window of ones
    // is representable and never wraps.
    assign cnt_nxt = cnt + {{CNT_LOG2{1'b0}}, out_bit};

    always_comb begin
        result_nxt = cnt[CNT_LOG2 - 1 -: WIDTH];
        if (cnt[CNT_LOG2]) begin
            result_nxt = '1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state        <= ST_IDLE;
            mode_q       <= 2'b00;
            op_a         <= '0;
            op_b         <= '0;
            bit_idx      <= '0;
            lfsr_a       <= SEED_A_EFF;
            lfsr_b       <= SEED_B_EFF;
            lfsr_s       <= SEED_S_EFF;
            cnt          <= '0;
            win          <= '0;
            result       <= '0;
            result_ovf   <= 1'b0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state   <= ST_LOAD;
                        mode_q  <= mode;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        op_a[bit_idx] <= ser_a;
                        op_b[bit_idx] <= ser_b;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_RUN;
                            cnt   <= '0;
                            win   <= '1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    // x^31 + x^28 + 1, shifting left; every RUN cycle steps.
                    lfsr_a <= {lfsr_a[29:0], lfsr_a[30] ^ lfsr_a[27]};
                    lfsr_b <= {lfsr_b[29:0], lfsr_b[30] ^ lfsr_b[27]};
                    lfsr_s <= {lfsr_s[29:0], lfsr_s[30] ^ lfsr_s[27]};
                    if (abort) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt_nxt;
                        // win is loaded with 2^CNT_LOG2-1, so the terminal
                        // count lands on the last of 2^CNT_LOG2 cycles.
                        if (win == '0) begin
                            state <= ST_DONE;
                        end else begin
                            win <= win - 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    result_valid <= 1'b1;
                    result       <= result_nxt;
                    result_ovf   <= cnt[CNT_LOG2];
                    if (cont) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                        win   <= '1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
